pipelined_look_ahead_adder: RTL and testbench



---
 rtl/pipelined_look_ahead_adder.sv | 232 +++++++++++++++++++++++
 tb/tb_pipelined_look_ahead_adder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_look_ahead_adder.sv
// ---------------------------------------------------------------------------
// pipelined_look_ahead_adder
//
// Streaming carry-look-ahead adder/subtractor. Each pipeline stage resolves
// one BLOCK-bit slice with a two-level look-ahead: 4-bit groups produce group
// generate/propagate terms, and a second level derives every group carry
// directly from the slice carry-in (no ripple between groups). The slice
// carry-out is registered into the next stage. Unprocessed upper operand bits
// and completed lower sum bits travel with their token, so the pipeline is
// skewed and sustains one result per cycle.
//
// Parameters
//   SIZE     operand / sum width, multiple of BLOCK
//   BLOCK    bits resolved per stage, multiple of 4 (STAGES = SIZE/BLOCK)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, discards in-flight tokens
//   in_valid   operands valid            in_ready   operands accepted
//   input_1    operand A                 input_2    operand B
//   carry_in   carry into bit 0 (add mode only)
//   sub        0 = A + B + carry_in, 1 = A - B
//   out_valid  result valid              out_ready  downstream accepts result
//   sum        result                    carry      MSB carry-out (1 = no borrow)
//   overflow   two's-complement overflow
//
// Build option
//   LA_ADDER_SATURATE_EN  when defined, an overflowing result is clamped to
//   the signed extreme selected by A's sign; otherwise the sum wraps.
// ---------------------------------------------------------------------------
module pipelined_look_ahead_adder #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned BLOCK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] input_1,
  input  logic [SIZE-1:0] input_2,
  input  logic            carry_in,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] sum,
  output logic            carry,
  output logic            overflow
);

  localparam int unsigned STAGES = SIZE / BLOCK;
  localparam int unsigned GROUPS = BLOCK / 4;

  // One BLOCK-bit slice: returns {carry_out, sum[BLOCK-1:0]}.
  function automatic logic [BLOCK:0] cla_slice(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             cin
  );
    logic [BLOCK-1:0]  g;
    logic [BLOCK-1:0]  p;
    logic [BLOCK-1:0]  c;
    logic [GROUPS-1:0] gg;
    logic [GROUPS-1:0] gp;
    logic [GROUPS:0]   gc;
    logic              term;
    g = a & b;
    p = a ^ b;
    for (int unsigned j = 0; j < GROUPS; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Second level: each group carry is a flat sum of products over the
    // lower groups and cin, so the loops unroll into parallel logic.
    gc    = '0;
    gc[0] = cin;
    for (int unsigned j = 1; j <= GROUPS; j++) begin
      term = cin;
      for (int unsigned m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int unsigned i = 0; i < j; i++) begin
        term = gg[i];
        for (int unsigned m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    for (int unsigned j = 0; j < GROUPS; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[GROUPS], p ^ c};
  endfunction

  // -------------------------------------------------------------------------
  // Elastic handshake
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] load;

  // Stage k may load when any stage at or after k is empty or the output is
  // being popped; this is the unrolled form of load[k] = !v[k] | load[k+1].
  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      logic free;
      free = out_ready;
      for (int unsigned m = k; m < STAGES; m++) free = free | ~v_q[m];
      load[k] = free;
    end
  end

  always_comb begin
    v_d = v_q;
    if (load[0]) v_d[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (load[k]) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];

  // -------------------------------------------------------------------------
  // Effective operands
  // -------------------------------------------------------------------------
  logic [SIZE-1:0] b_eff;
  logic            c_eff;

  assign b_eff = sub ? ~input_2 : input_2;
  assign c_eff = sub | carry_in;

  // -------------------------------------------------------------------------
  // Skewed datapath stages
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IN = SIZE - k * BLOCK;   // operand bits pending on entry
    localparam int unsigned LO = (k + 1) * BLOCK;    // sum bits complete on exit

    logic [IN-1:0]  src_a;
    logic [IN-1:0]  src_b;
    logic           src_c;
    logic           en;
    logic [BLOCK:0] res;
    logic [LO-1:0]  sum_raw;
    logic [LO-1:0]  sum_d;
    logic [LO-1:0]  sum_q;
    logic           c_q;

    if (k == 0) begin : g_src
      assign src_a   = input_1;
      assign src_b   = b_eff;
      assign src_c   = c_eff;
      assign en      = load[0] & in_valid;
      assign sum_raw = res[BLOCK-1:0];
    end else begin : g_src
      assign src_a   = g_stage[k-1].g_hi.a_q;
      assign src_b   = g_stage[k-1].g_hi.b_q;
      assign src_c   = g_stage[k-1].c_q;
      assign en      = load[k] & v_q[k-1];
      assign sum_raw = {res[BLOCK-1:0], g_stage[k-1].sum_q};
    end

    assign res = cla_slice(src_a[BLOCK-1:0], src_b[BLOCK-1:0], src_c);

    // Data registers only update when a real token enters, so a stalled or
    // idle output keeps its value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        c_q   <= res[BLOCK];
      end
    end

    if (k < STAGES - 1) begin : g_hi
      logic [IN-BLOCK-1:0] a_q;
      logic [IN-BLOCK-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= src_a[IN-1:BLOCK];
          b_q <= src_b[IN-1:BLOCK];
        end
      end

      assign sum_d = sum_raw;
    end else begin : g_last
      logic ov_d;
      logic ov_q;

      // Carry-into-MSB XOR carry-out equals "operand signs agree and the
      // result sign differs", which avoids exporting the MSB carry-in.
      assign ov_d = (src_a[IN-1] ~^ src_b[IN-1]) & (res[BLOCK-1] ^ src_a[IN-1]);

`ifdef LA_ADDER_SATURATE_EN
      assign sum_d = !ov_d        ? sum_raw :
                     src_a[IN-1]  ? {1'b1, {(SIZE-1){1'b0}}} :
                                    {1'b0, {(SIZE-1){1'b1}}};
`else
      assign sum_d = sum_raw;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     ov_q <= 1'b0;
        else if (en) ov_q <= ov_d;
      end

      assign sum      = sum_q;
      assign carry    = c_q;
      assign overflow = ov_q;
    end
  end

endmodule

// File: tb/tb_pipelined_look_ahead_adder.sv
module tb_pipelined_look_ahead_adder;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned BLOCK = 4;
  localparam int          MOD   = 1 << SIZE;
  localparam int          HALF  = 1 << (SIZE - 1);

  typedef struct packed {
    logic [SIZE-1:0] s;
    logic            c;
    logic            v;
  } exp_t;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] input_1   = '0;
  logic [SIZE-1:0] input_2   = '0;
  logic            carry_in  = 1'b0;
  logic            sub       = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SIZE-1:0] sum;
  logic            carry;
  logic            overflow;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  bit          rand_ready = 1'b0;
  int unsigned burst_acc  = 0;
  bit          saw_block  = 1'b0;
  int unsigned block_at   = 0;

  pipelined_look_ahead_adder #(.SIZE(SIZE), .BLOCK(BLOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .input_1  (input_1),
    .input_2  (input_2),
    .carry_in (carry_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [SIZE-1:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s;
    e.c = c;
    e.v = v;
    return e;
  endfunction

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                 input logic ci, input logic s);
    exp_t e;
    int ua, ub, sa, sbv, r, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= HALF) ? ua - MOD : ua;
    sbv = (ub >= HALF) ? ub - MOD : ub;
    if (s) begin
      r   = ua - ub;
      e.c = (ua >= ub);
      sr  = sa - sbv;
    end else begin
      r   = ua + ub + int'(ci);
      e.c = (r >= MOD);
      sr  = sa + sbv + int'(ci);
    end
    e.v = (sr > HALF - 1) || (sr < -HALF);
    e.s = r[SIZE-1:0];
`ifdef LA_ADDER_SATURATE_EN
    if (e.v) e.s = (ua < HALF) ? SIZE'(HALF - 1) : SIZE'(HALF);
`endif
    return e;
  endfunction

  function automatic logic [SIZE-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return {1'b0, {(SIZE-1){1'b1}}};
      2:       return {1'b1, {(SIZE-1){1'b0}}};
      3:       return '1;
      default: return SIZE'($urandom);
    endcase
  endfunction

  // Present one operation from posedge+1 until accepted; on acceptance the
  // expected response joins the scoreboard. Returns at posedge+1.
  task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                      input logic ci, input logic s, input exp_t e);
    int unsigned waited = 0;
    bit          ok     = 1'b0;
    input_1  = a;
    input_2  = b;
    carry_in = ci;
    sub      = s;
    in_valid = 1'b1;
    while (waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      if (!saw_block) begin
        saw_block = 1'b1;
        block_at  = burst_acc;
      end
      waited++;
    end
    if (ok) begin
      sb.push_back(e);
      burst_acc++;
    end else begin
      chk("accept_timeout", in_ready, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(sb.size() == 0 && !out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output transfer, and checks that a stalled
  // result stays put.
  initial begin : monitor
    bit              held;
    logic [SIZE-1:0] held_s;
    logic            held_c;
    logic            held_v;
    exp_t            e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, held_s);
        chk("hold_carry", carry, held_c);
        chk("hold_ovf", overflow, held_v);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("out_sum", sum, e.s);
          chk("out_carry", carry, e.c);
          chk("out_ovf", overflow, e.v);
        end
        held = 1'b0;
      end else if (out_valid) begin
        held   = 1'b1;
        held_s = sum;
        held_c = carry;
        held_v = overflow;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : ready_toggler
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [SIZE-1:0] a, b;
    logic            ci, s;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency on an empty pipeline: result in the second cycle after accept
    send(8'd22, 8'd23, 1'b0, 1'b0, mk(8'd45, 1'b0, 1'b0));
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Directed cases
    send(8'd200, 8'd100, 1'b1, 1'b0, mk(8'h2D, 1'b1, 1'b0));
    send(8'd5,   8'd7,   1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0));
    send(8'd7,   8'd5,   1'b0, 1'b1, mk(8'd2,  1'b1, 1'b0));
    send(8'd7,   8'd5,   1'b1, 1'b1, mk(8'd2,  1'b1, 1'b0));
`ifdef LA_ADDER_SATURATE_EN
    send(8'd127, 8'd1,   1'b0, 1'b0, mk(8'h7F, 1'b0, 1'b1));
    send(8'h80,  8'd1,   1'b0, 1'b1, mk(8'h80, 1'b1, 1'b1));
`else
    send(8'd127, 8'd1,   1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
    send(8'h80,  8'd1,   1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1));
`endif
    send(8'hFF,  8'h01,  1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0));
    drain("directed");

    // Backpressure: 6 back-to-back ops, output stalled for 4 cycles
    out_ready = 1'b0;
    burst_acc = 0;
    saw_block = 1'b0;
    block_at  = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          a  = pick();
          b  = pick();
          ci = 1'($urandom);
          s  = 1'($urandom);
          send(a, b, ci, s, model(a, b, ci, s));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_on_pop", in_ready, 1);
        chk("bp_out_valid_full", out_valid, 1);
      end
    join
    chk("bp_saw_block", saw_block, 1);
    chk("bp_accepts_before_block", block_at, 2);
    drain("backpressure");

    // Reset with two tokens in flight
    out_ready = 1'b0;
    send(8'd10, 8'd20, 1'b0, 1'b0, mk(8'd30, 1'b0, 1'b0));
    send(8'd40, 8'd3,  1'b0, 1'b1, mk(8'd37, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_carry", carry, 0);
    chk("midrst_ovf", overflow, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with bubbles and random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        a  = pick();
        b  = pick();
        ci = 1'($urandom);
        s  = 1'($urandom);
        send(a, b, ci, s, model(a, b, ci, s));
      end
    end
    rand_ready = 1'b0;
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
